// File: rtl/mpc_vec4_serializer_if.sv
// Bus bundle for mpc_vec4_serializer: vector input handshake, register bank
// outputs feeding the 4:1 operand mux, and the serial output handshake.
// The slave modport is the serializer itself; master is its environment.
interface mpc_vec4_serializer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] in_vec0;
   logic [DATA_WIDTH-1:0] in_vec1;
   logic [DATA_WIDTH-1:0] in_vec2;
   logic [DATA_WIDTH-1:0] in_vec3;
   logic                  in_vld;
   logic                  in_rdy;
   logic [DATA_WIDTH-1:0] bank0;
   logic [DATA_WIDTH-1:0] bank1;
   logic [DATA_WIDTH-1:0] bank2;
   logic [DATA_WIDTH-1:0] bank3;
   logic [1:0]            sel;
   logic                  out_vld;
   logic                  out_rdy;
   logic                  out_last;
   logic                  busy;

   modport master (
      output in_vec0, in_vec1, in_vec2, in_vec3, in_vld, out_rdy,
      input  in_rdy, bank0, bank1, bank2, bank3, sel, out_vld, out_last, busy
   );

   modport slave (
      input  in_vec0, in_vec1, in_vec2, in_vec3, in_vld, out_rdy,
      output in_rdy, bank0, bank1, bank2, bank3, sel, out_vld, out_last, busy
   );
endinterface

// File: rtl/mpc_vec4_serializer.sv
// Vector-to-serial front end for the controller's 4:1 operand mux.
// A whole vector is captured into the bank in one transfer; the mux select
// then walks over the first NUM_ELEM elements, one per accepted output beat.
// A new vector may be taken during the last beat so streaming has no bubble.
// NUM_ELEM must be 2..4; DATA_WIDTH must match the interface instance.
module mpc_vec4_serializer #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_ELEM   = 4,
   parameter int REVERSE    = 0
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   mpc_vec4_serializer_if.slave   bus
);

   localparam logic [1:0] FIRST_SEL = (REVERSE != 0) ? 2'(NUM_ELEM - 1) : 2'd0;
   localparam logic [1:0] LAST_CNT  = 2'(NUM_ELEM - 1);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t     state;
   logic [1:0] cnt;
   logic       accept;
   logic       beat;

   // Ready to take a vector when idle, or during the final beat of a vector.
   // The STREAM term is a deliberate combinational path from out_rdy.
   always_comb begin
      // NOTE: default first so every path assigns in_rdy and no latch is inferred.
      bus.in_rdy = 1'b0;
      if (ap_rst_n) begin
         if (state == IDLE) begin
            bus.in_rdy = 1'b1;
         end else begin
            bus.in_rdy = bus.out_vld && bus.out_rdy && bus.out_last;
         end
      end
   end

   assign accept = bus.in_vld && bus.in_rdy;
   assign beat   = bus.out_vld && bus.out_rdy;

   // Bank registers load only on an input accept and are otherwise held.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      // NOTE: the bank is reset because it drives the mux directly and a
      // reset mid-stream must visibly discard the held vector.
      if (!ap_rst_n) begin
         bus.bank0 <= {DATA_WIDTH{1'b0}};
         bus.bank1 <= {DATA_WIDTH{1'b0}};
         bus.bank2 <= {DATA_WIDTH{1'b0}};
         bus.bank3 <= {DATA_WIDTH{1'b0}};
      end else if (accept) begin
         // NOTE: non-blocking assignments for all clocked state so every
         // register samples pre-edge values regardless of statement order.
         bus.bank0 <= bus.in_vec0;
         bus.bank1 <= bus.in_vec1;
         bus.bank2 <= bus.in_vec2;
         bus.bank3 <= bus.in_vec3;
      end
   end

   // Two-state sequencer owning the element counter, select and all status outputs.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state        <= IDLE;
         cnt          <= 2'd0;
         bus.sel      <= 2'd0;
         bus.out_vld  <= 1'b0;
         bus.out_last <= 1'b0;
         bus.busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state        <= STREAM;
                  cnt          <= 2'd0;
                  bus.sel      <= FIRST_SEL;
                  bus.out_vld  <= 1'b1;
                  bus.out_last <= 1'b0;
                  bus.busy     <= 1'b1;
               end
            end
            STREAM: begin
               if (beat) begin
                  if (bus.out_last) begin
                     if (accept) begin
                        // Reload without a bubble: restart the walk on the new vector.
                        cnt          <= 2'd0;
                        bus.sel      <= FIRST_SEL;
                        bus.out_last <= 1'b0;
                     end else begin
                        state        <= IDLE;
                        bus.out_vld  <= 1'b0;
                        bus.out_last <= 1'b0;
                        bus.busy     <= 1'b0;
                     end
                  end else begin
                     cnt          <= cnt + 2'd1;
                     bus.sel      <= (REVERSE != 0) ? bus.sel - 2'd1 : bus.sel + 2'd1;
                     bus.out_last <= ((cnt + 2'd1) == LAST_CNT);
                  end
               end
            end
            default: begin
               state        <= IDLE;
               bus.out_vld  <= 1'b0;
               bus.out_last <= 1'b0;
               bus.busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mpc_vec4_serializer.md
Name: mpc_vec4_serializer

Overview:
- Upstream feeder for the controller's 4:1 32-bit operand mux.
- Accepts one vector of up to four 32-bit words in a single valid/ready transfer and holds it in a register bank.
- Walks the 2-bit mux select over the bank, presenting one word per accepted output beat.
- Lets the downstream datapath consume an operand vector serially through the existing mux without stalling the vector producer more than necessary.

Parameters:
- DATA_WIDTH, 32, width of each vector element and each bank register.
- NUM_ELEM, 4, number of elements streamed per vector; legal values 2..4. Elements at index NUM_ELEM and above are never selected.
- REVERSE, 0, 0 = select order 0,1,..,NUM_ELEM-1; 1 = order NUM_ELEM-1,..,0.

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous reset, active low.
- in_vec0  in  DATA_WIDTH  vector element 0.
- in_vec1  in  DATA_WIDTH  vector element 1.
- in_vec2  in  DATA_WIDTH  vector element 2.
- in_vec3  in  DATA_WIDTH  vector element 3.
- in_vld  in  1  input vector valid.
- in_rdy  out  1  block can accept a vector this cycle.
- bank0  out  DATA_WIDTH  registered element 0, to mux data input 0.
- bank1  out  DATA_WIDTH  registered element 1, to mux data input 1.
- bank2  out  DATA_WIDTH  registered element 2, to mux data input 2.
- bank3  out  DATA_WIDTH  registered element 3, to mux data input 3.
- sel  out  2  mux select, to mux select input.
- out_vld  out  1  mux output currently holds a valid element.
- out_rdy  in  1  downstream accepts the current element.
- out_last  out  1  current element is the final one of the vector.
- busy  out  1  a vector is held and not fully consumed.

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - state = IDLE.
  - bank0..3 = 0, sel = 0, elem counter = 0.
  - out_vld = 0, out_last = 0, busy = 0.
  - in_rdy forced 0 while ap_rst_n is low.
- Reset mid-stream discards the held vector. No partial output beats follow the release of reset.
- FSM with two states, IDLE and STREAM.
- IDLE:
  - in_rdy = 1.
  - On in_vld && in_rdy: capture in_vec0..3 into bank0..3, cnt = 0, sel = first index (0, or NUM_ELEM-1 if REVERSE), go to STREAM.
  - Latency from input accept to out_vld = 1 is one cycle.
- STREAM:
  - out_vld = 1, busy = 1.
  - out_last = 1 when cnt == NUM_ELEM-1.
  - Beat transfers on out_vld && out_rdy.
  - Non-last beat: cnt += 1; sel steps +1 (or -1 if REVERSE). The new sel is registered and visible the next cycle.
  - Last beat with no new vector accepted in the same cycle: go to IDLE and clear out_vld.
- Back-to-back vectors:
  - In STREAM, in_rdy = out_vld && out_rdy && out_last. This is a combinational path from out_rdy and is intentional.
  - If in_vld is also high in that cycle, the bank reloads, cnt and sel reset to the first index, state stays STREAM, and out_vld stays 1 with no bubble.
- Stall: while out_rdy = 0, bank, sel, cnt, out_last are all held stable. A new vector is never accepted.
- Bank registers change only on an input accept. They are never modified during streaming.
- in_vec inputs are sampled only on accept. Input changes at any other time have no effect.
- sel never takes a value at or above NUM_ELEM. Wrap-around is impossible because the FSM leaves or reloads at the last element.
- out_last is asserted only together with out_vld.

Test Plan:
- Single vector, NUM_ELEM=4, REVERSE=0, out_rdy tied 1: in_vec = 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> sel 0,1,2,3 on 4 consecutive cycles starting one cycle after accept; out_last only on sel=3; then out_vld=0 and in_rdy=1.
- Back-to-back: second vector 0xA0..0xA3 held on in_vld during the last beat -> in_rdy=1 that cycle; sel returns to 0 the next cycle with bank0=0xA0; out_vld never drops (8 beats in 8 cycles).
- Backpressure: out_rdy low for 3 cycles at sel=1 -> sel, bank1 and out_last=0 stay stable; in_rdy=0 throughout; streaming resumes at sel=2.
- REVERSE=1, NUM_ELEM=3: vector 5,6,7,8 -> sel 2,1,0; out_last at sel=0; element 3 (value 8) never selected.
- Reset mid-stream: assert ap_rst_n low while sel=2 -> bank0..3, sel, out_vld and busy go to 0 immediately without a clock edge; after release, in_rdy=1 and out_vld stays 0 until a new accept.
- Input ignored while busy: toggle in_vec with in_vld=1 during STREAM with out_rdy=0 -> bank contents unchanged, no accept occurs.
